bias_relu_quant: RTL and testbench

Post-processing stage directly downstream of the matrix-vector multiplier. It captures a full vector of signed accumulator results and adds a per-row bias to each element. It then applies ReLU, rounds and right-shifts, and saturates to the data width. Elements stream out one per handshake to the next layer, and the block also assembles the full quantized vector for the layer buffer.

---
 rtl/bias_relu_quant.sv | 140 ++++++++++++++
 tb/tb_bias_relu_quant.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bias_relu_quant.sv
// Bias-add, ReLU, round-shift and saturate stage behind the matrix-vector multiplier.
// Streams quantized elements one per handshake and assembles the whole result vector.
module bias_relu_quant #(
    parameter int ROWS      = 6,
    parameter int ACC_WIDTH = 20,
    parameter int WIDTH     = 8,
    parameter int SHIFT     = 4,
    parameter int IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ROWS*ACC_WIDTH-1:0] acc_vector,
    input  logic [ROWS*WIDTH-1:0]     bias_vector,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      busy,
    output logic                      done,
    output logic [ROWS*WIDTH-1:0]     result_vector
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int QW = ACC_WIDTH + 2;
    // (2**SHIFT)/2 is zero when SHIFT is zero, so no rounding term is added then.
    localparam logic [QW-1:0]    ROUND = QW'((2 ** SHIFT) / 2);
    localparam logic [QW-1:0]    SAT   = QW'((2 ** (WIDTH - 1)) - 1);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(ROWS - 1);

    state_t                       state_q;
    logic                         valid_q;
    logic                         busy_q;
    logic                         done_q;
    logic [WIDTH-1:0]             data_q;
    logic [IDX_W-1:0]             idx_q;
    logic [IDX_W-1:0]             idx_d;
    logic signed [ACC_WIDTH-1:0]  acc_in [ROWS];
    logic signed [WIDTH-1:0]      bias_in [ROWS];
    logic signed [ACC_WIDTH-1:0]  acc_q [ROWS];
    logic signed [WIDTH-1:0]      bias_q [ROWS];
    logic [WIDTH-1:0]             res_q [ROWS];

    function automatic logic [WIDTH-1:0] quant(
        input logic signed [ACC_WIDTH-1:0] acc,
        input logic signed [WIDTH-1:0]     bias
    );
        logic [ACC_WIDTH:0] s;
        logic [QW-1:0]      r;
        logic [QW-1:0]      q;
        s = {acc[ACC_WIDTH-1], acc}
            + {{(ACC_WIDTH + 1 - WIDTH){bias[WIDTH-1]}}, bias};
        r = s[ACC_WIDTH] ? '0 : {1'b0, s};
        q = (r + ROUND) >> SHIFT;
        if (q > SAT) begin
            return SAT[WIDTH-1:0];
        end
        return q[WIDTH-1:0];
    endfunction

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_slot
            assign acc_in[gi]  = acc_vector[gi*ACC_WIDTH +: ACC_WIDTH];
            assign bias_in[gi] = bias_vector[gi*WIDTH +: WIDTH];
            assign result_vector[gi*WIDTH +: WIDTH] = res_q[gi];
        end
    endgenerate

    assign idx_d = idx_q + IDX_W'(1);

    // Operand capture only happens on an accepted start, so a start while busy
    // leaves the working copy untouched.
    always_ff @(posedge clk) begin
        if (!reset && state_q == IDLE && start) begin
            for (int i = 0; i < ROWS; i++) begin
                acc_q[i]  <= acc_in[i];
                bias_q[i] <= bias_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            for (int i = 0; i < ROWS; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        data_q  <= quant(acc_in[0], bias_in[0]);
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        res_q[idx_q] <= data_q;
                        if (idx_q == LAST) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q  <= idx_d;
                            data_q <= quant(acc_q[idx_d], bias_q[idx_d]);
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bias_relu_quant.sv
// Directed-vector bench with a queue scoreboard and a free-running monitor.
module tb_bias_relu_quant;

    localparam int ROWS      = 6;
    localparam int ACC_WIDTH = 20;
    localparam int WIDTH     = 8;
    localparam int SHIFT     = 4;
    localparam int IDX_W     = 3;

    typedef int vec_t[ROWS];
    typedef struct {
        int idx;
        int data;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      start;
    logic [ROWS*ACC_WIDTH-1:0] acc_vector;
    logic [ROWS*WIDTH-1:0]     bias_vector;
    logic                      out_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [IDX_W-1:0]          out_idx;
    logic                      busy;
    logic                      done;
    logic [ROWS*WIDTH-1:0]     result_vector;

    int tests    = 0;
    int fails    = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;

    exp_t                  sb[$];
    logic [ROWS*WIDTH-1:0] rv_q[$];

    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic [IDX_W-1:0] prev_idx;

    bias_relu_quant #(
        .ROWS(ROWS), .ACC_WIDTH(ACC_WIDTH), .WIDTH(WIDTH), .SHIFT(SHIFT), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .acc_vector(acc_vector), .bias_vector(bias_vector),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_idx(out_idx), .busy(busy), .done(done), .result_vector(result_vector)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(prev_data));
                chk("stall_idx", 64'(out_idx), 64'(prev_idx));
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_handshake: idx %0d data %0d required none", out_idx, out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("hs_idx", 64'(out_idx), 64'(e.idx));
                    chk("hs_data", 64'(out_data), 64'(e.data));
                    $display("[TB] handshake idx=%0d data=%0d expected idx=%0d data=%0d",
                             out_idx, out_data, e.idx, e.data);
                end
            end
            if (done) begin
                done_cnt++;
                if (rv_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: result_vector 0x%0h required no done", result_vector);
                end else begin
                    chk("result_vector", 64'(result_vector), 64'(rv_q.pop_front()));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
        end
    end

    task automatic load_vectors(input vec_t acc, input vec_t bias);
        for (int i = 0; i < ROWS; i++) begin
            acc_vector[i*ACC_WIDTH +: ACC_WIDTH] = acc[i][ACC_WIDTH-1:0];
            bias_vector[i*WIDTH +: WIDTH]        = bias[i][WIDTH-1:0];
        end
    endtask

    task automatic run_case(input string name, input vec_t acc, input vec_t bias,
                            input vec_t exp, input logic [7:0] rpat, input bit poke);
        logic [ROWS*WIDTH-1:0] rv;
        int exp_done;
        int k;
        int cyc;
        int hs0;
        int d0;
        exp_t e;
        load_vectors(acc, bias);
        for (int i = 0; i < ROWS; i++) begin
            e.idx  = i;
            e.data = exp[i];
            sb.push_back(e);
            rv[i*WIDTH +: WIDTH] = exp[i][WIDTH-1:0];
        end
        rv_q.push_back(rv);
        // Cycle offset of done: one past the cycle of the last accepted element.
        k = 0;
        exp_done = 0;
        while (k < ROWS) begin
            if (rpat[exp_done % 8]) k++;
            exp_done++;
        end
        hs0 = hs_cnt;
        d0  = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, " valid_k+1"}, 64'(out_valid), 64'd1);
        chk({name, " idx_k+1"}, 64'(out_idx), 64'd0);
        cyc = 0;
        while (!done && cyc < 60) begin
            out_ready = rpat[cyc % 8];
            if (poke && cyc == 1) begin
                start       = 1'b1;
                acc_vector  = '1;
                bias_vector = '1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        chk({name, " done_cycle"}, 64'(cyc), 64'(exp_done));
        @(posedge clk); #1;
        chk({name, " busy_after"}, 64'(busy), 64'd0);
        chk({name, " done_pulse_width"}, 64'(done), 64'd0);
        chk({name, " handshakes"}, 64'(hs_cnt - hs0), 64'(ROWS));
        chk({name, " done_count"}, 64'(done_cnt - d0), 64'd1);
        chk({name, " sb_empty"}, 64'(sb.size()), 64'd0);
        $display("[TB] case %s done at cycle offset %0d (expected %0d)", name, cyc, exp_done);
    endtask

    initial begin
        int hs0;
        exp_t e;
        reset       = 1'b1;
        start       = 1'b0;
        out_ready   = 1'b0;
        acc_vector  = '0;
        bias_vector = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data", 64'(out_data), 64'd0);
        chk("reset out_idx", 64'(out_idx), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result_vector", 64'(result_vector), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_case("basic", '{16, 32, 48, 64, 80, 96}, '{0, 0, 0, 0, 0, 0},
                 '{1, 2, 3, 4, 5, 6}, 8'hFF, 1'b0);
        run_case("relu_bias", '{-100, 10, 0, 5, -1, 100}, '{0, -20, 0, 3, 1, -4},
                 '{0, 0, 0, 1, 0, 6}, 8'hFF, 1'b0);
        run_case("rounding", '{7, 8, 23, 24, 15, 40}, '{0, 0, 0, 0, 0, 0},
                 '{0, 1, 1, 2, 1, 3}, 8'hFF, 1'b0);
        run_case("saturation", '{2023, 2031, 2040, 4000, 524287, -524288},
                 '{0, 0, 0, 0, 127, -128}, '{126, 127, 127, 127, 127, 0}, 8'hFF, 1'b0);
        // Ready pattern 1,0,0,1,0,1,1,1 (bit 0 first), with a start pulse mid-run.
        run_case("backpressure", '{16, 32, 48, 64, 80, 96}, '{0, 0, 0, 0, 0, 0},
                 '{1, 2, 3, 4, 5, 6}, 8'b1110_1001, 1'b1);

        // Reset after the third accepted element.
        load_vectors('{16, 32, 48, 64, 80, 96}, '{0, 0, 0, 0, 0, 0});
        for (int i = 0; i < 3; i++) begin
            e.idx  = i;
            e.data = i + 1;
            sb.push_back(e);
        end
        hs0   = hs_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midreset handshakes", 64'(hs_cnt - hs0), 64'd3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b0;
        chk("midreset out_valid", 64'(out_valid), 64'd0);
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset out_idx", 64'(out_idx), 64'd0);
        chk("midreset out_data", 64'(out_data), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        chk("midreset result_vector", 64'(result_vector), 64'd0);
        sb.delete();
        rv_q.delete();
        @(posedge clk); #1;
        run_case("after_reset", '{16, 32, 48, 64, 80, 96}, '{0, 0, 0, 0, 0, 0},
                 '{1, 2, 3, 4, 5, 6}, 8'hFF, 1'b0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
